cursor_ctrl: RTL and testbench
==============================

CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 SHALL take parameter DEBOUNCE_CYCLES, default 1_000_000; a raw button counts as stable after this many consecutive equal synchronised samples (10 ms at 100 MHz).
REQ-002 SHALL take parameter REPEAT_DELAY, default 50_000_000; hold time before auto-repeat starts.
REQ-003 SHALL take parameter REPEAT_PERIOD, default 10_000_000; cycles between auto-repeat steps.
REQ-004 CLOCK  in  1  sole clock, 100 MHz, all state on its rising edge.
REQ-005 RESETN  in  1  asynchronous, active-low reset.
REQ-006 btnU, btnD, btnL, btnR  in  1 each  raw, unsynchronised push-buttons.
REQ-007 enable  in  1  high = cursor movement allowed (driven low by clear/palette modes).
REQ-008 curr_pixel_x  out  8  cursor column, range 0..94.
REQ-009 curr_pixel_y  out  8  cursor row, range 0..62.
REQ-010 moved  out  1  one-cycle pulse, same cycle the position registers take a new value.

Function
REQ-011 SHALL pass each button through a 2-flop synchroniser, then a debouncer whose output toggles only after DEBOUNCE_CYCLES equal samples differing from its current output; any differing sample restarts that button's counter.
REQ-012 SHALL form the direction vector from debounced levels: dx = R-L, dy = D-U; U+D together gives dy=0; L+R together gives dx=0.
REQ-013 SHALL run FSM states IDLE, DELAY and REPEAT.
REQ-014 IDLE: on nonzero direction, step once on the next edge and go to DELAY with the timer cleared.
REQ-015 DELAY: after REPEAT_DELAY cycles with an unchanged nonzero direction, step and go to REPEAT with the timer cleared.
REQ-016 REPEAT: step every REPEAT_PERIOD cycles while the direction is unchanged.
REQ-017 In DELAY or REPEAT, a direction change to another nonzero value SHALL step immediately in the new direction and re-enter DELAY with the timer cleared.
REQ-018 In any state, a direction change to zero SHALL go to IDLE with no step.
REQ-019 A step SHALL add dx to x and dy to y in the same cycle; diagonal steps are allowed.
REQ-020 Each axis SHALL saturate at 0 and at its maximum (x 94, y 62, keeping the 2x2 cursor on the 96x64 panel); there is no wrap-around.
REQ-021 moved SHALL assert only when at least one coordinate actually changes; a step blocked at a boundary on both axes gives moved=0.
REQ-022 enable low SHALL hold the position, force IDLE, clear the timer and suppress moved; debouncers keep running.
REQ-023 When enable rises while a direction is held, the FSM SHALL treat it as a fresh press from IDLE and step on the next edge.
REQ-024 Timers SHALL be wide enough for the largest parameter and SHALL never overflow; arithmetic on coordinates SHALL use 8-bit unsigned with explicit saturation compare before update.
REQ-025 Latency from a clean raw press edge to moved SHALL be exactly 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-026 RESETN low SHALL asynchronously set curr_pixel_x=47, curr_pixel_y=31, moved=0, FSM=IDLE, all timers and debounce counters 0, and synchroniser and debounced levels 0.
REQ-027 Reset deasserted mid-hold SHALL restart from IDLE; the first step needs a full debounce interval.

Structure
REQ-028 Shared package draw_pkg SHALL hold OLED_W=96, OLED_H=64, CURSOR_X_MAX=94, CURSOR_Y_MAX=62, CURSOR_X_HOME=47, CURSOR_Y_HOME=31, and the cursor FSM state enum.
REQ-029 SHALL instantiate sub-module btn_debounce (synchroniser plus counter, parameter DEBOUNCE_CYCLES) four times, one per button.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-030 Reset, then hold btnR clean from cycle 10 -> moved at cycle 17, x=48, y=31; no further step before cycle 37.
REQ-031 Hold btnR 60 cycles -> steps at debounce+1, +20, then every 5 -> x=47+1+1+7=56, moved count 9.
REQ-032 btnL bounce pattern 1,0,1,1,0 then steady 1 -> single step only after 4 stable samples; x=46.
REQ-033 From x=94, y=62 hold btnR+btnD -> no change, moved stays 0; release, hold btnU+btnD -> no step.
REQ-034 Hold btnU, switch to btnU+btnL in DELAY -> immediate diagonal step (x-1, y-1), timer restarts; drop enable -> position frozen, moved 0.
REQ-035 Assert RESETN low mid-REPEAT -> outputs return to 47/31 within the same cycle, moved=0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared drawing constants for the 96x64 OLED panel and the cursor FSM state type.
package draw_pkg;

  localparam int unsigned OLED_W = 96;
  localparam int unsigned OLED_H = 64;

  localparam logic [7:0] CURSOR_X_MAX  = 8'd94;
  localparam logic [7:0] CURSOR_Y_MAX  = 8'd62;
  localparam logic [7:0] CURSOR_X_HOME = 8'd47;
  localparam logic [7:0] CURSOR_Y_HOME = 8'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } cursor_state_t;

  // One saturating step along a single axis; inc and dec are never both set.
  function automatic logic [7:0] axis_step(input logic [7:0] pos, input logic inc,
                                           input logic dec, input logic [7:0] pos_max);
    logic [7:0] nxt;
    nxt = pos;
    if (inc && (pos < pos_max)) nxt = pos + 8'd1;
    else if (dec && (pos != 8'd0)) nxt = pos - 8'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counter debouncer for one raw push-button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic CLOCK,
  input  logic RESETN,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      // Any sample matching the current level restarts the stability count.
      if (sync_b == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_level <= sync_b;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor position controller: debounced buttons drive a step / hold-delay / auto-repeat FSM.
module cursor_ctrl
  import draw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       enable,
  output logic [7:0] curr_pixel_x,
  output logic [7:0] curr_pixel_y,
  output logic       moved
);

  localparam int unsigned TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic lvl_u, lvl_d, lvl_l, lvl_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
    .CLOCK(CLOCK), .RESETN(RESETN), .btn_raw(btnU), .btn_level(lvl_u));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .CLOCK(CLOCK), .RESETN(RESETN), .btn_raw(btnD), .btn_level(lvl_d));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .CLOCK(CLOCK), .RESETN(RESETN), .btn_raw(btnL), .btn_level(lvl_l));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .CLOCK(CLOCK), .RESETN(RESETN), .btn_raw(btnR), .btn_level(lvl_r));

  // Direction as one-hot-per-axis flags {x+, x-, y+, y-}; opposing presses cancel.
  logic [3:0] dir;
  logic [3:0] dir_prev;
  logic       dir_active;
  logic       dir_changed;

  assign dir         = {lvl_r & ~lvl_l, lvl_l & ~lvl_r, lvl_d & ~lvl_u, lvl_u & ~lvl_d};
  assign dir_active  = |dir;
  assign dir_changed = (dir != dir_prev);

  cursor_state_t state, state_nxt;
  logic [TW-1:0] timer;
  logic          do_step;
  logic          timer_clr;
  logic [7:0]    step_x;
  logic [7:0]    step_y;

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable || !dir_active) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_nxt = ST_DELAY;
        ST_DELAY:  if (dir_changed) state_nxt = ST_DELAY;
                   else if (timer == DELAY_LAST) state_nxt = ST_REPEAT;
        ST_REPEAT: if (dir_changed) state_nxt = ST_DELAY;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    do_step   = 1'b0;
    timer_clr = 1'b1;
    if (enable && dir_active) begin
      case (state)
        ST_IDLE:   do_step = 1'b1;
        ST_DELAY:  if (dir_changed || (timer == DELAY_LAST)) do_step = 1'b1;
                   else timer_clr = 1'b0;
        ST_REPEAT: if (dir_changed || (timer == PERIOD_LAST)) do_step = 1'b1;
                   else timer_clr = 1'b0;
        default:   do_step = 1'b0;
      endcase
    end
  end

  assign step_x = axis_step(curr_pixel_x, dir[3], dir[2], CURSOR_X_MAX);
  assign step_y = axis_step(curr_pixel_y, dir[1], dir[0], CURSOR_Y_MAX);

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      timer        <= '0;
      dir_prev     <= '0;
      curr_pixel_x <= CURSOR_X_HOME;
      curr_pixel_y <= CURSOR_Y_HOME;
      moved        <= 1'b0;
    end else begin
      dir_prev <= dir;
      timer    <= timer_clr ? '0 : timer + TW'(1);
      if (do_step) begin
        curr_pixel_x <= step_x;
        curr_pixel_y <= step_y;
      end
      moved <= do_step && ((step_x != curr_pixel_x) || (step_y != curr_pixel_y));
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: directed scenarios plus random button play against a cycle-indexed reference model.
module tb_cursor_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int HMAX = 8192;

  logic       CLOCK  = 1'b0;
  logic       RESETN = 1'b1;
  logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic       enable = 1'b1;
  logic [7:0] curr_pixel_x, curr_pixel_y;
  logic       moved;

  cursor_ctrl #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .enable(enable), .curr_pixel_x(curr_pixel_x), .curr_pixel_y(curr_pixel_y), .moved(moved));

  always #5 CLOCK = ~CLOCK;

  int checks   = 0;
  int failures = 0;

  // Reference model: raw history per edge since reset; buttons 0=U 1=D 2=L 3=R.
  bit hist [4][HMAX];
  bit m_db [4];
  int m_e, m_due, m_ldx, m_ldy, m_x, m_y;
  bit m_moved;
  int dut_moves;
  int last_mv_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit synced(input int b, input int t);
    if (t < 2) return 1'b0;
    return hist[b][t-2];
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_x = 47; m_y = 31; m_e = 0; m_due = -1; m_ldx = 0; m_ldy = 0; m_moved = 1'b0;
    for (int b = 0; b < 4; b++) m_db[b] = 1'b0;
    dut_moves = 0; last_mv_edge = -1;
  endtask

  // Advance the model by one rising edge using the inputs present before it.
  task automatic model_edge();
    int dx, dy, nx, ny;
    bit stepped, flip;
    if (m_e >= HMAX - 1) begin
      $display("FAIL model_history_overflow edge=%0d limit=%0d", m_e, HMAX);
      $fatal(1);
    end
    hist[0][m_e] = btnU; hist[1][m_e] = btnD; hist[2][m_e] = btnL; hist[3][m_e] = btnR;
    dx = int'(m_db[3]) - int'(m_db[2]);
    dy = int'(m_db[1]) - int'(m_db[0]);
    stepped = 1'b0;
    if (!enable || (dx == 0 && dy == 0)) begin
      m_due = -1;
    end else if (m_due < 0 || dx != m_ldx || dy != m_ldy) begin
      stepped = 1'b1; m_due = m_e + RD;
    end else if (m_e == m_due) begin
      stepped = 1'b1; m_due = m_e + RP;
    end
    nx = stepped ? clamp(m_x + dx, 94) : m_x;
    ny = stepped ? clamp(m_y + dy, 62) : m_y;
    m_moved = (nx != m_x) || (ny != m_y);
    m_x = nx; m_y = ny;
    m_ldx = dx; m_ldy = dy;
    // Level flips once the last DB synchronised samples all disagree with it.
    for (int b = 0; b < 4; b++) begin
      flip = (m_e >= DB - 1);
      for (int j = 0; j < DB; j++) if (synced(b, m_e - j) == m_db[b]) flip = 1'b0;
      if (flip) m_db[b] = ~m_db[b];
    end
    m_e++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLOCK);
    @(negedge CLOCK);
    check("x", {24'd0, curr_pixel_x}, 32'(m_x));
    check("y", {24'd0, curr_pixel_y}, 32'(m_y));
    check("moved", {31'd0, moved}, {31'd0, m_moved});
    if (moved === 1'b1) begin
      dut_moves++;
      last_mv_edge = m_e - 1;
    end
  endtask

  // Asynchronous reset asserted between edges; released on a falling edge.
  task automatic apply_reset();
    #2 RESETN = 1'b0;
    #1;
    check("rst_x", {24'd0, curr_pixel_x}, 32'd47);
    check("rst_y", {24'd0, curr_pixel_y}, 32'd31);
    check("rst_moved", {31'd0, moved}, 32'd0);
    @(negedge CLOCK);
    model_reset();
    RESETN = 1'b1;
  endtask

  task automatic release_all();
    btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1);
  end

  initial begin
    int first_mv, second_mv, snap, n;
    bit [4:0] pat;

    // Single press: latency, hold-off, then auto-repeat.
    apply_reset();
    repeat (11) tick();
    btnR = 1'b1;
    first_mv = -1; second_mv = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (moved === 1'b1 && first_mv < 0) begin
        first_mv = m_e - 1;
        check("first_step_x", {24'd0, curr_pixel_x}, 32'd48);
        check("first_step_y", {24'd0, curr_pixel_y}, 32'd31);
      end else if (moved === 1'b1 && second_mv < 0) begin
        second_mv = m_e - 1;
      end
    end
    check("first_step_edge", 32'(first_mv), 32'd17);
    check("second_step_edge", 32'(second_mv), 32'd37);
    btnR = 1'b0;
    repeat (20) tick();
    check("hold60_moves", 32'(dut_moves), 32'd9);
    check("hold60_x", {24'd0, curr_pixel_x}, 32'd56);

    // Bouncing left press steps exactly once.
    apply_reset();
    repeat (3) tick();
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btnL = pat[i];
      tick();
    end
    btnL = 1'b1;
    repeat (12) tick();
    btnL = 1'b0;
    repeat (15) tick();
    check("bounce_x", {24'd0, curr_pixel_x}, 32'd46);
    check("bounce_moves", 32'(dut_moves), 32'd1);

    // Drive into the bottom-right corner, then confirm blocked and cancelling presses.
    apply_reset();
    btnR = 1'b1; btnD = 1'b1;
    n = 0;
    while (!(curr_pixel_x == 8'd94 && curr_pixel_y == 8'd62) && n < 600) begin
      tick();
      n++;
    end
    check("corner_reached", {31'd0, (n < 600)}, 32'd1);
    release_all();
    repeat (15) tick();
    snap = dut_moves;
    btnR = 1'b1; btnD = 1'b1;
    repeat (40) tick();
    check("corner_blocked_moves", 32'(dut_moves - snap), 32'd0);
    release_all();
    repeat (15) tick();
    btnU = 1'b1; btnD = 1'b1;
    repeat (40) tick();
    check("ud_cancel_moves", 32'(dut_moves - snap), 32'd0);
    check("ud_cancel_y", {24'd0, curr_pixel_y}, 32'd62);
    release_all();
    repeat (10) tick();

    // Direction change in DELAY, then enable gating.
    apply_reset();
    btnU = 1'b1;
    repeat (10) tick();
    check("up_first_y", {24'd0, curr_pixel_y}, 32'd30);
    btnL = 1'b1;
    snap = dut_moves;
    n = 0;
    while (dut_moves == snap && n < 20) begin
      tick();
      n++;
    end
    check("diag_within_bound", {31'd0, (n < 20)}, 32'd1);
    check("diag_x", {24'd0, curr_pixel_x}, 32'd46);
    check("diag_y", {24'd0, curr_pixel_y}, 32'd29);
    repeat (4) tick();
    enable = 1'b0;
    snap = dut_moves;
    repeat (40) tick();
    check("disabled_moves", 32'(dut_moves - snap), 32'd0);
    check("disabled_x", {24'd0, curr_pixel_x}, 32'd46);
    enable = 1'b1;
    tick();
    check("enable_rise_step", {31'd0, moved}, 32'd1);
    release_all();
    repeat (10) tick();

    // Reset during auto-repeat while the button stays held.
    apply_reset();
    btnR = 1'b1;
    repeat (50) tick();
    apply_reset();
    repeat (12) tick();
    check("post_reset_first_step_edge", 32'(last_mv_edge), 32'd6);
    release_all();
    repeat (10) tick();

    // Random button play with occasional bounce and enable drops.
    apply_reset();
    for (int seg = 0; seg < 60; seg++) begin
      {btnU, btnD, btnL, btnR} = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 7) != 0);
      n = $urandom_range(1, 45);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: btnU = ~btnU;
            1: btnD = ~btnD;
            2: btnL = ~btnL;
            default: btnR = ~btnR;
          endcase
        end
        tick();
      end
    end
    release_all();
    enable = 1'b1;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
